leb128_pack_signed_stream: RTL
==============================

Name: leb128_pack_signed_stream

Overview:
- Sequential signed-LEB128 encoder: the transmit-side counterpart to the unpack_signed decoder.
- Accepts one N-bit two's-complement word over a valid/ready handshake and emits its LEB128 byte sequence one byte per cycle on a valid/ready byte stream, flagging the final byte.
- Sits between core logic and a byte-serial bitstream writer, for example a WASM/DWARF emitter.

Parameters:
- N, 64: input word width in bits. Legal range 8..64.
- MAXB, (N+6)/7: maximum encoded length in bytes. Derived; must not be overridden.
- LW, 4: width of the byte index / length fields. Must satisfy 2^LW > MAXB.

Ports:
- clk  input  1  clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a word to encode.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  N  two's-complement value to encode.
- out_valid  output  1  out_data holds a byte.
- out_ready  input  1  sink accepts the byte this cycle.
- out_data  output  8  LEB128 byte; bit7 is the continuation bit.
- out_last  output  1  current byte is the final byte of the word (bit7 = 0).
- out_idx  output  LW  index of the current byte within the word, 0-based.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, shift register = 0, out_idx = 0, out_valid = 0, out_last = 0, out_data = 0, in_ready = 0 while rst_n is low. in_ready goes to 1 on the first clk edge after rst_n deasserts.
- State IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready, load the shift register with in_data, set out_idx = 0, go to EMIT.
- State EMIT:
  - out_valid = 1.
  - Let s be the shift register and t = s >>> 7 (arithmetic shift).
  - Define sign6 = s[6].
  - Define done = (t is all-zero & sign6 = 0) | (t is all-ones & sign6 = 1) | (out_idx = MAXB-1).
  - out_data = {~done, s[6:0]}; out_last = done. Both are combinational from registered state.
  - On out_valid & out_ready & ~done: s <= t, out_idx <= out_idx + 1, stay in EMIT.
  - On out_valid & out_ready & done: go to IDLE, or reload from the input (see back-to-back rule).
  - If out_ready = 0: hold out_data, out_last and out_idx stable; no state change.
- Back-to-back:
  - in_ready = IDLE | (EMIT & out_ready & done).
  - A word accepted in the same cycle as the last byte handshake loads directly, and byte 0 of the new word is valid on the next cycle, with no bubble.
- Latency and throughput:
  - First byte is valid 1 cycle after input acceptance.
  - Throughput is one byte per cycle under continuous out_ready.
  - A k-byte word occupies exactly k cycles of out_valid.
- Width rule:
  - The final byte at index MAXB-1 carries the remaining sign-extended bits in s[6:0].
  - Bits of the final byte above bit N-1-7*(MAXB-1) are the sign bit.
- Boundary cases:
  - Input 0 yields the single byte 0x00.
  - Input -1 yields the single byte 0x7F.
  - Values 63 and -64 yield one byte; values 64 and -65 yield two bytes.
- in_data is sampled only on handshake; changes to it at other times have no effect.
- Reset asserted mid-word aborts the word immediately. No partial output follows.

Optional Feature:
- Macro: LEB128_UNSIGNED_MODE_EN.
- Defined:
  - Adds input port in_unsigned (1 bit), sampled with in_data on handshake.
  - When the sampled value is 1, the word is encoded as unsigned LEB128:
    - shift is logical (t = s >> 7, zero fill);
    - done = (t is all-zero) | (out_idx = MAXB-1);
    - sign6 is ignored.
  - When the sampled value is 0, behaviour is signed as described above.
- Not defined: the port is absent and encoding is always signed.

Test Plan:
- After reset, in_data = 1 -> one byte 0x01, out_last = 1, out_idx = 0.
- in_data = -1 -> one byte 0x7F, out_last = 1. in_data = -64 -> 0x40. in_data = 64 -> bytes 0xC0, 0x00.
- in_data = 64'h00000000c0000000 -> bytes 0x80, 0x80, 0x80, 0x80, 0x0C, with out_last only on idx 4.
- in_data = 64'h8000000000000000 -> nine bytes 0x80 then 0x7F, with out_idx ending at 9.
- Backpressure and back-to-back:
  - Random out_ready stalls on 64'h6000000000 -> bytes 0x80 x5, 0x0C (6 bytes), with data held during stalls.
  - A second word (5) offered during the last byte is accepted in that same cycle, and 0x05 is valid on the next cycle.
- Reset pulse mid-word (after byte 2 of 64'hc000000000000000) -> out_valid drops at once; after release, 3 encodes cleanly as 0x03.
- With LEB128_UNSIGNED_MODE_EN defined: in_unsigned = 1 with all-ones input -> nine bytes 0xFF then 0x01; in_unsigned = 0 with the same input -> 0x7F.

Source files
------------

// File: rtl/leb128_pack_signed_stream.sv
// leb128_pack_signed_stream: serial signed-LEB128 encoder, one byte per cycle with valid/ready on both sides.
// Define LEB128_UNSIGNED_MODE_EN to add the in_unsigned port for per-word unsigned encoding.
module leb128_pack_signed_stream #(
  parameter int N  = 64,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef LEB128_UNSIGNED_MODE_EN
  input  logic          in_unsigned,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_last,
  output logic [LW-1:0] out_idx
);
  localparam int MAXB = (N + 6) / 7;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  s_q, s_d, t;
  logic [LW-1:0] idx_q, idx_d;
  logic          up_q, uns_q, done, fill;

`ifdef LEB128_UNSIGNED_MODE_EN
  logic uns_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) uns_q <= 1'b0;
    else        uns_q <= uns_d;
`else
  assign uns_q = 1'b0;
`endif

  // The shift is built by hand so the fill bit is explicit for both modes.
  always_comb begin
    fill      = ~uns_q & s_q[N-1];
    t         = {{7{fill}}, s_q[N-1:7]};
    done      = (idx_q == LW'(MAXB - 1)) |
                (uns_q ? (t == '0) : ((t == '0) & ~s_q[6]) | ((&t) & s_q[6]));
    out_valid = (state_q == EMIT);
    out_last  = out_valid & done;
    out_data  = out_valid ? {~done, s_q[6:0]} : 8'h00;
    out_idx   = idx_q;
    in_ready  = up_q & ((state_q == IDLE) | (out_valid & out_ready & done));
    state_d   = state_q;
    s_d       = s_q;
    idx_d     = idx_q;
`ifdef LEB128_UNSIGNED_MODE_EN
    uns_d     = uns_q;
`endif
    if (out_valid & out_ready) begin
      state_d = done ? IDLE : EMIT;
      s_d     = done ? s_q : t;
      idx_d   = done ? idx_q : idx_q + 1'b1;
    end
    if (in_valid & in_ready) begin
      state_d = EMIT;
      s_d     = in_data;
      idx_d   = '0;
`ifdef LEB128_UNSIGNED_MODE_EN
      uns_d   = in_unsigned;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      idx_q   <= '0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      up_q    <= 1'b1;
    end
  end
endmodule
